// File: rtl/ycbcr_bin_pkg.sv
// ycbcr_bin_pkg: shared constants for the YCbCr window binarizer.
// Holds the default geometry, reset thresholds, control-register bit
// positions and the register-map layout.
package ycbcr_bin_pkg;

    localparam int DEF_CW    = 8;
    localparam int DEF_NCH   = 3;
    localparam int DEF_CNT_W = 22;
    localparam int DEF_AW    = 4;

    // Reset thresholds, channel 0 (Y) in the MSBs
    localparam logic [DEF_NCH*DEF_CW-1:0] DEF_TL_INIT = {8'd40,  8'd100, 8'd160};
    localparam logic [DEF_NCH*DEF_CW-1:0] DEF_TH_INIT = {8'd150, 8'd155, 8'd240};

    // Register map for the default channel count
    localparam int ADDR_TL_BASE = 0;
    localparam int ADDR_TH_BASE = DEF_NCH;
    localparam int ADDR_CTRL    = 2 * DEF_NCH;

    // Control register layout: bit0 invert, bits[NCH:1] channel enable mask
    localparam int CTRL_INVERT_BIT = 0;
    localparam int CTRL_MASK_LSB   = 1;

    // Register-map helpers for an arbitrary channel count
    function automatic int addrThBase(input int nch);
        return nch;
    endfunction

    function automatic int addrCtrl(input int nch);
        return 2 * nch;
    endfunction

endpackage

// File: rtl/ycbcr_window_binarize_if.sv
// ycbcr_window_binarize_if: pixel stream, config port and result bundle.
// The master side drives pixels/config and observes results; the slave
// side is the binarizer.
interface ycbcr_window_binarize_if
    import ycbcr_bin_pkg::*;
#(
    parameter int CW    = DEF_CW,
    parameter int NCH   = DEF_NCH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int AW    = DEF_AW
);
    localparam int DW = CW * NCH;

    logic [DW-1:0]    i_pix;
    logic             i_hsync;
    logic             i_vsync;
    logic             i_de;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [CW-1:0]    cfg_data;
    logic [DW-1:0]    o_binary;
    logic             o_hsync;
    logic             o_vsync;
    logic             o_de;
    logic             o_cfg_pending;
    logic [CNT_W-1:0] o_match_cnt;
    logic             o_cnt_valid;

    modport master (
        output i_pix, i_hsync, i_vsync, i_de, cfg_we, cfg_addr, cfg_data,
        input  o_binary, o_hsync, o_vsync, o_de, o_cfg_pending, o_match_cnt, o_cnt_valid
    );

    modport slave (
        input  i_pix, i_hsync, i_vsync, i_de, cfg_we, cfg_addr, cfg_data,
        output o_binary, o_hsync, o_vsync, o_de, o_cfg_pending, o_match_cnt, o_cnt_valid
    );

endinterface

// File: rtl/ycbcr_bin_regs.sv
// ycbcr_bin_regs: shadow/active threshold bank for the window binarizer.
// Writes land in the shadow set; the active set copies the pre-write shadow
// on each vsync rising edge, so a frame never mixes settings.
// With YCBCR_BIN_STATS_EN defined the commit strobe is exported for the
// per-frame match counter.
module ycbcr_bin_regs
    import ycbcr_bin_pkg::*;
#(
    parameter int                  CW      = DEF_CW,
    parameter int                  NCH     = DEF_NCH,
    parameter int                  AW      = DEF_AW,
    parameter logic [NCH*CW-1:0]   TL_INIT = DEF_TL_INIT,
    parameter logic [NCH*CW-1:0]   TH_INIT = DEF_TH_INIT
) (
    input  logic                     pixelclk,
    input  logic                     reset,
    input  logic                     cfgWe_i,
    input  logic [AW-1:0]            cfgAddr_i,
    input  logic [CW-1:0]            cfgData_i,
    input  logic                     vsync_i,
    output logic [0:NCH-1][CW-1:0]   activeTl_o,
    output logic [0:NCH-1][CW-1:0]   activeTh_o,
    output logic [NCH-1:0]           activeMask_o,
    output logic                     activeInv_o,
`ifdef YCBCR_BIN_STATS_EN
    output logic                     commit_o,
`endif
    output logic                     pending_o
);

    logic [0:NCH-1][CW-1:0] shTl_q, shTl_d, shTh_q, shTh_d;
    logic [0:NCH-1][CW-1:0] acTl_q, acTh_q;
    logic [NCH-1:0]         shMask_q, shMask_d, acMask_q;
    logic                   shInv_q, shInv_d, acInv_q;
    logic                   vsync_q;
    logic                   pending_q, pending_d;
    logic                   validWrite;
    logic                   commit;

    assign commit = vsync_i & ~vsync_q;

    // Decode config writes into the next shadow values and the pending flag
    always_comb begin
        shTl_d     = shTl_q;
        shTh_d     = shTh_q;
        shMask_d   = shMask_q;
        shInv_d    = shInv_q;
        validWrite = 1'b0;
        if (cfgWe_i) begin
            for (int k = 0; k < NCH; k++) begin
                if (cfgAddr_i == AW'(ADDR_TL_BASE + k)) begin
                    shTl_d[k]  = cfgData_i;
                    validWrite = 1'b1;
                end
                if (cfgAddr_i == AW'(addrThBase(NCH) + k)) begin
                    shTh_d[k]  = cfgData_i;
                    validWrite = 1'b1;
                end
            end
            if (cfgAddr_i == AW'(addrCtrl(NCH))) begin
                shInv_d    = cfgData_i[CTRL_INVERT_BIT];
                shMask_d   = cfgData_i[CTRL_MASK_LSB +: NCH];
                validWrite = 1'b1;
            end
        end
        if (validWrite) begin
            pending_d = 1'b1;
        end else if (commit) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Shadow bank, pending flag and vsync edge-detect history
    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            shTl_q    <= TL_INIT;
            shTh_q    <= TH_INIT;
            shMask_q  <= '1;
            shInv_q   <= 1'b0;
            pending_q <= 1'b0;
            vsync_q   <= 1'b0;
        end else begin
            shTl_q    <= shTl_d;
            shTh_q    <= shTh_d;
            shMask_q  <= shMask_d;
            shInv_q   <= shInv_d;
            pending_q <= pending_d;
            vsync_q   <= vsync_i;
        end
    end

    // Active bank takes the pre-write shadow contents at frame start
    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            acTl_q   <= TL_INIT;
            acTh_q   <= TH_INIT;
            acMask_q <= '1;
            acInv_q  <= 1'b0;
        end else if (commit) begin
            acTl_q   <= shTl_q;
            acTh_q   <= shTh_q;
            acMask_q <= shMask_q;
            acInv_q  <= shInv_q;
        end
    end

    assign activeTl_o   = acTl_q;
    assign activeTh_o   = acTh_q;
    assign activeMask_o = acMask_q;
    assign activeInv_o  = acInv_q;
    assign pending_o    = pending_q;
`ifdef YCBCR_BIN_STATS_EN
    assign commit_o     = commit;
`endif

endmodule

// File: rtl/ycbcr_window_binarize.sv
// ycbcr_window_binarize: per-channel inclusive window test on a YCbCr pixel
// producing an all-zero / all-one binary pixel, two-cycle latency with
// delay-matched syncs. Optional feature macro YCBCR_BIN_STATS_EN adds a
// per-frame matched-pixel counter reported at each frame start.
module ycbcr_window_binarize
    import ycbcr_bin_pkg::*;
#(
    parameter int                  CW      = DEF_CW,
    parameter int                  NCH     = DEF_NCH,
    parameter int                  DW      = CW * NCH,
    parameter logic [NCH*CW-1:0]   TL_INIT = DEF_TL_INIT,
    parameter logic [NCH*CW-1:0]   TH_INIT = DEF_TH_INIT,
    parameter int                  CNT_W   = DEF_CNT_W,
    parameter int                  AW      = DEF_AW
) (
    input  logic                   pixelclk,
    input  logic                   reset,
    ycbcr_window_binarize_if.slave bus
);

    logic [0:NCH-1][CW-1:0] actTl, actTh, pixCh;
    logic [NCH-1:0]         actMask;
    logic                   actInv;
    logic                   pending;
`ifdef YCBCR_BIN_STATS_EN
    logic                   commit;
`endif

    logic [NCH-1:0] hitS1_d, hitS1_q, maskS1_q;
    logic           invS1_q, hsS1_q, vsS1_q, deS1_q;
    logic           matchS1;
    logic [DW-1:0]  binary_d, binary_q;
    logic           hsS2_q, vsS2_q, deS2_q;

    ycbcr_bin_regs #(
        .CW      (CW),
        .NCH     (NCH),
        .AW      (AW),
        .TL_INIT (TL_INIT),
        .TH_INIT (TH_INIT)
    ) u_regs (
        .pixelclk     (pixelclk),
        .reset        (reset),
        .cfgWe_i      (bus.cfg_we),
        .cfgAddr_i    (bus.cfg_addr),
        .cfgData_i    (bus.cfg_data),
        .vsync_i      (bus.i_vsync),
        .activeTl_o   (actTl),
        .activeTh_o   (actTh),
        .activeMask_o (actMask),
        .activeInv_o  (actInv),
`ifdef YCBCR_BIN_STATS_EN
        .commit_o     (commit),
`endif
        .pending_o    (pending)
    );

    // Channel 0 sits in the MSBs, which matches the ascending packed index
    assign pixCh = bus.i_pix;

    // Unsigned inclusive window test per channel; TL > TH can never hit
    always_comb begin
        hitS1_d = '0;
        for (int k = 0; k < NCH; k++) begin
            hitS1_d[k] = (pixCh[k] >= actTl[k]) && (pixCh[k] <= actTh[k]);
        end
    end

    // Stage 1 captures hits together with the settings they were judged by
    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            hitS1_q  <= '0;
            maskS1_q <= '0;
            invS1_q  <= 1'b0;
            hsS1_q   <= 1'b0;
            vsS1_q   <= 1'b0;
            deS1_q   <= 1'b0;
        end else begin
            hitS1_q  <= hitS1_d;
            maskS1_q <= actMask;
            invS1_q  <= actInv;
            hsS1_q   <= bus.i_hsync;
            vsS1_q   <= bus.i_vsync;
            deS1_q   <= bus.i_de;
        end
    end

    // Disabled channels always pass; matched pixels are black unless inverted
    assign matchS1  = &(hitS1_q | ~maskS1_q);
    assign binary_d = {DW{~matchS1 ^ invS1_q}};

    // Stage 2 registers the binary pixel and the delayed syncs
    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            binary_q <= '0;
            hsS2_q   <= 1'b0;
            vsS2_q   <= 1'b0;
            deS2_q   <= 1'b0;
        end else begin
            binary_q <= binary_d;
            hsS2_q   <= hsS1_q;
            vsS2_q   <= vsS1_q;
            deS2_q   <= deS1_q;
        end
    end

    assign bus.o_binary      = binary_q;
    assign bus.o_hsync       = hsS2_q;
    assign bus.o_vsync       = vsS2_q;
    assign bus.o_de          = deS2_q;
    assign bus.o_cfg_pending = pending;

`ifdef YCBCR_BIN_STATS_EN
    logic             matchS2_q;
    logic             countThis;
    logic [CNT_W-1:0] cnt_q, matchCnt_q;
    logic             cntValid_q;

    assign countThis = matchS2_q & deS2_q;

    // Saturating matched-pixel count, reported and restarted at frame start
    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            matchS2_q  <= 1'b0;
            cnt_q      <= '0;
            matchCnt_q <= '0;
            cntValid_q <= 1'b0;
        end else begin
            matchS2_q <= matchS1;
            if (commit) begin
                matchCnt_q <= cnt_q;
                cnt_q      <= countThis ? CNT_W'(1) : '0;
                cntValid_q <= 1'b1;
            end else begin
                cntValid_q <= 1'b0;
                if (countThis && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.o_match_cnt = matchCnt_q;
    assign bus.o_cnt_valid = cntValid_q;
`else
    assign bus.o_match_cnt = '0;
    assign bus.o_cnt_valid = 1'b0;
`endif

endmodule
